// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit controller port, with pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef OpcodeBus
`define OpcodeBus 6:0
`endif
`ifndef OptBus
`define OptBus 3:0
`endif

module mem_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic [`OpcodeBus]  in_opcode,
    input  logic [`OptBus]     in_opt,
    input  logic              in_we,
    input  logic [`RegAddrBus] in_waddr,
    input  logic [`RegBus]     in_alu,
    input  logic [`RegBus]     in_rdata2,
    input  logic              in_flag,
    output logic              mc_req,
    output logic              mc_rw,
    output logic [31:0]       mc_addr,
    output logic [7:0]        mc_wdata,
    input  logic              mc_done,
    input  logic [7:0]        mc_rdata,
    output logic              stall_req,
    output logic              wb_we,
    output logic [`RegAddrBus] wb_waddr,
    output logic [`RegBus]     wb_wdata,
    output logic              mis_err
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [3:0] OPT_LB  = 4'd0;
    localparam logic [3:0] OPT_LH  = 4'd1;
    localparam logic [3:0] OPT_LW  = 4'd2;
    localparam logic [3:0] OPT_LBU = 4'd3;
    localparam logic [3:0] OPT_LHU = 4'd4;
    localparam logic [3:0] OPT_SB  = 4'd5;
    localparam logic [3:0] OPT_SH  = 4'd6;
    localparam logic [3:0] OPT_SW  = 4'd7;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic [3:0]  opt_q;
    logic [4:0]  waddr_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] asm_q;

    logic in_is_mem, in_load_ok, in_store_ok, go;
    logic load_q, store_q;
    logic [1:0] last_cnt;

    assign in_is_mem   = (in_opcode == OPC_LOAD) || (in_opcode == OPC_STORE);
    assign in_load_ok  = (in_opcode == OPC_LOAD) &&
                         (in_opt == OPT_LB || in_opt == OPT_LH || in_opt == OPT_LW ||
                          in_opt == OPT_LBU || in_opt == OPT_LHU);
    assign in_store_ok = (in_opcode == OPC_STORE) &&
                         (in_opt == OPT_SB || in_opt == OPT_SH || in_opt == OPT_SW);
    // Memory opcodes with an unknown opt never start an access (NOP).
    assign go = in_flag && (in_load_ok || in_store_ok);

    assign load_q  = (opt_q == OPT_LB) || (opt_q == OPT_LH) || (opt_q == OPT_LW) ||
                     (opt_q == OPT_LBU) || (opt_q == OPT_LHU);
    assign store_q = (opt_q == OPT_SB) || (opt_q == OPT_SH) || (opt_q == OPT_SW);

    always_comb begin
        last_cnt = 2'd3;
        case (opt_q)
            OPT_LB, OPT_LBU, OPT_SB: last_cnt = 2'd0;
            OPT_LH, OPT_LHU, OPT_SH: last_cnt = 2'd1;
            default:                 last_cnt = 2'd3;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_q;
    logic in_misalign;
    assign in_misalign = ((in_opt == OPT_LH || in_opt == OPT_LHU || in_opt == OPT_SH) && in_alu[0]) ||
                         ((in_opt == OPT_LW || in_opt == OPT_SW) && (in_alu[1:0] != 2'b00));
    assign mis_err = (state == DONE) && mis_q;
`else
    assign mis_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            opt_q   <= 4'd0;
            waddr_q <= 5'd0;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            asm_q   <= 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (go) begin
                    opt_q   <= in_opt;
                    waddr_q <= in_waddr;
                    addr_q  <= in_alu;
                    sdata_q <= in_rdata2;
                    asm_q   <= 32'd0;
                    cnt     <= 2'd0;
`ifdef MEM_MISALIGN_CHECK_EN
                    mis_q   <= in_misalign;
                    state   <= in_misalign ? DONE : ACCESS;
`else
                    state   <= ACCESS;
`endif
                end
                ACCESS: if (mc_done) begin
                    if (load_q) asm_q[{cnt, 3'b000} +: 8] <= mc_rdata;
                    if (cnt == last_cnt) state <= DONE;
                    else                 cnt   <= cnt + 2'd1;
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEM_MISALIGN_CHECK_EN
                    mis_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mc_req    = (state == ACCESS);
    assign mc_rw     = mc_req && store_q;
    assign mc_addr   = mc_req ? addr_q + {30'd0, cnt} : 32'd0;
    assign mc_wdata  = (mc_req && store_q) ? sdata_q[{cnt, 3'b000} +: 8] : 8'd0;
    assign stall_req = (state == ACCESS) || ((state == IDLE) && go);

    always_comb begin
        wb_we    = 1'b0;
        wb_waddr = waddr_q;
        wb_wdata = 32'd0;
        case (state)
            IDLE: begin
                wb_we    = in_we && !in_is_mem;
                wb_waddr = in_waddr;
                wb_wdata = in_alu;
            end
            DONE: begin
`ifdef MEM_MISALIGN_CHECK_EN
                wb_we = load_q && !mis_q;
`else
                wb_we = load_q;
`endif
                case (opt_q)
                    OPT_LB:  wb_wdata = {{24{asm_q[7]}}, asm_q[7:0]};
                    OPT_LH:  wb_wdata = {{16{asm_q[15]}}, asm_q[15:0]};
                    OPT_LBU: wb_wdata = {24'd0, asm_q[7:0]};
                    OPT_LHU: wb_wdata = {16'd0, asm_q[15:0]};
                    default: wb_wdata = asm_q;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected bus/write-back events, a negedge monitor
// models the controller (done in the same cycle as each request) and checks them.
module tb_mem_stage;
    localparam logic [6:0] OPC_ALU = 7'b0110011, OPC_LD = 7'b0000011, OPC_ST = 7'b0100011;
    localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4,
                           SB = 4'd5, SH = 4'd6, SW = 4'd7, BAD = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  in_opcode;
    logic [3:0]  in_opt;
    logic        in_we;
    logic [4:0]  in_waddr;
    logic [31:0] in_alu, in_rdata2;
    logic        in_flag;
    logic        mc_req, mc_rw, mc_done;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata, mc_rdata;
    logic        stall_req, wb_we, mis_err;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_opcode(in_opcode), .in_opt(in_opt), .in_we(in_we),
        .in_waddr(in_waddr), .in_alu(in_alu), .in_rdata2(in_rdata2), .in_flag(in_flag),
        .mc_req(mc_req), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_done(mc_done), .mc_rdata(mc_rdata), .stall_req(stall_req), .wb_we(wb_we),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .mis_err(mis_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic rw; logic [31:0] addr; logic [7:0] wdata; } mc_t;
    typedef struct { logic [4:0] waddr; logic [31:0] wdata; } wb_t;
    mc_t        mc_q[$];
    wb_t        wb_q[$];
    logic [7:0] rd_q[$];
    int checks = 0, errors = 0, mis_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [7:0] b);
        mc_t e;
        e.rw = 1'b0; e.addr = a; e.wdata = 8'd0;
        mc_q.push_back(e);
        rd_q.push_back(b);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] b);
        mc_t e;
        e.rw = 1'b1; e.addr = a; e.wdata = b;
        mc_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [4:0] wa, input logic [31:0] d);
        wb_t e;
        e.waddr = wa; e.wdata = d;
        wb_q.push_back(e);
    endtask

    // Controller model + monitor.
    always @(negedge clk) begin
        mc_t me;
        wb_t we_e;
        if (rst) begin
            mc_done  = 1'b0;
            mc_rdata = 8'd0;
        end else begin
            mc_done  = mc_req;
            mc_rdata = (mc_req && !mc_rw && rd_q.size() > 0) ? rd_q.pop_front() : 8'd0;
            if (mc_req) begin
                if (mc_q.size() == 0) chk("mc_unexpected", {31'd0, mc_req}, 32'd0);
                else begin
                    me = mc_q.pop_front();
                    chk("mc_addr", mc_addr, me.addr);
                    chk("mc_rw", {31'd0, mc_rw}, {31'd0, me.rw});
                    if (me.rw) chk("mc_wdata", {24'd0, mc_wdata}, {24'd0, me.wdata});
                end
            end
            if (wb_we) begin
                if (wb_q.size() == 0) chk("wb_unexpected", {31'd0, wb_we}, 32'd0);
                else begin
                    we_e = wb_q.pop_front();
                    chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, we_e.waddr});
                    chk("wb_wdata", wb_wdata, we_e.wdata);
                end
            end
            if (mis_err) mis_seen++;
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [3:0] opt, input logic we,
                         input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd2,
                         output int stalls);
        bit ended;
        stalls = 0;
        ended  = 1'b0;
        @(posedge clk); #1;
        in_opcode = opc; in_opt = opt; in_we = we; in_waddr = wa;
        in_alu = alu; in_rdata2 = rd2; in_flag = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_req) begin ended = 1'b1; break; end
            stalls++;
            @(posedge clk); #1 in_flag = 1'b0;
        end
        if (!ended) chk("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_flag = 1'b0; in_opcode = 7'd0; in_opt = 4'd0; in_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        rst = 1'b1; in_opcode = 7'd0; in_opt = 4'd0; in_we = 1'b0; in_waddr = 5'd0;
        in_alu = 32'd0; in_rdata2 = 32'd0; in_flag = 1'b0;
        #13;
        chk("rst_mc_req", {31'd0, mc_req}, 32'd0);
        chk("rst_mc_rw", {31'd0, mc_rw}, 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        chk("rst_mc_wdata", {24'd0, mc_wdata}, 32'd0);
        chk("rst_mis_err", {31'd0, mis_err}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // ALU passthrough, zero latency
        exp_wb(5'd5, 32'h1234);
        issue(OPC_ALU, 4'd0, 1'b1, 5'd5, 32'h1234, 32'd0, st);
        chk("alu_stalls", st, 0);

        // LW at 0x100
        exp_rd(32'h100, 8'h78); exp_rd(32'h101, 8'h56); exp_rd(32'h102, 8'h34); exp_rd(32'h103, 8'h12);
        exp_wb(5'd7, 32'h12345678);
        issue(OPC_LD, LW, 1'b1, 5'd7, 32'h100, 32'd0, st);
        chk("lw_stalls", st, 5);

        // LB / LBU sign vs zero extension
        exp_rd(32'h20, 8'h80); exp_wb(5'd8, 32'hFFFFFF80);
        issue(OPC_LD, LB, 1'b1, 5'd8, 32'h20, 32'd0, st);
        chk("lb_stalls", st, 2);
        exp_rd(32'h20, 8'h80); exp_wb(5'd9, 32'h00000080);
        issue(OPC_LD, LBU, 1'b1, 5'd9, 32'h20, 32'd0, st);

        // LH / LHU
        exp_rd(32'h30, 8'h34); exp_rd(32'h31, 8'h92); exp_wb(5'd10, 32'hFFFF9234);
        issue(OPC_LD, LH, 1'b1, 5'd10, 32'h30, 32'd0, st);
        chk("lh_stalls", st, 3);
        exp_rd(32'h30, 8'h34); exp_rd(32'h31, 8'h92); exp_wb(5'd11, 32'h00009234);
        issue(OPC_LD, LHU, 1'b1, 5'd11, 32'h30, 32'd0, st);

        // Stores: SH, SB, SW wrapping past 0xFFFFFFFF
        exp_wr(32'h40, 8'hDD); exp_wr(32'h41, 8'hCC);
        issue(OPC_ST, SH, 1'b0, 5'd0, 32'h40, 32'hAABBCCDD, st);
        chk("sh_stalls", st, 3);
        exp_wr(32'h55, 8'h9A);
        issue(OPC_ST, SB, 1'b0, 5'd0, 32'h55, 32'h1234569A, st);
        exp_wr(32'hFFFFFFFE, 8'h44); exp_wr(32'hFFFFFFFF, 8'h33);
        exp_wr(32'h00000000, 8'h22); exp_wr(32'h00000001, 8'h11);
        issue(OPC_ST, SW, 1'b0, 5'd0, 32'hFFFFFFFE, 32'h11223344, st);
        chk("sw_stalls", st, 5);

        // Memory opcode with unknown opt: NOP
        issue(OPC_LD, BAD, 1'b1, 5'd12, 32'h300, 32'd0, st);
        chk("nop_stalls", st, 0);

        // Misaligned word load
`ifdef MEM_MISALIGN_CHECK_EN
        issue(OPC_LD, LW, 1'b1, 5'd13, 32'h102, 32'd0, st);
        chk("mis_stalls", st, 1);
        chk("mis_seen", mis_seen, 1);
`else
        exp_rd(32'h102, 8'h01); exp_rd(32'h103, 8'h02); exp_rd(32'h104, 8'h03); exp_rd(32'h105, 8'h04);
        exp_wb(5'd13, 32'h04030201);
        issue(OPC_LD, LW, 1'b1, 5'd13, 32'h102, 32'd0, st);
        chk("mis_stalls", st, 5);
        chk("mis_seen", mis_seen, 0);
`endif

        // Reset during the second byte of an LW
        exp_rd(32'h200, 8'hAA); exp_rd(32'h201, 8'hBB);
        @(posedge clk); #1;
        in_opcode = OPC_LD; in_opt = LW; in_we = 1'b1; in_waddr = 5'd14;
        in_alu = 32'h200; in_flag = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 in_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mc_req", {31'd0, mc_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_mid_addr", mc_addr, 32'd0);
        mc_q.delete(); rd_q.delete();
        in_opcode = 7'd0; in_opt = 4'd0; in_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        exp_rd(32'h20, 8'h7F); exp_wb(5'd15, 32'h0000007F);
        issue(OPC_LD, LB, 1'b1, 5'd15, 32'h20, 32'd0, st);

        repeat (2) @(posedge clk);
        chk("mc_q_left", mc_q.size(), 0);
        chk("wb_q_left", wb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
